// File: rtl/prim_mem.sv
// prim_mem: byte-addressed memory with a 16-bit request/ack bus port.
//
// Ports
//   i_clk    sole clock, rising edge
//   i_reset  asynchronous, active-high reset
//   i_addr   byte address (only the low AW bits select a byte; upper bits alias)
//   i_dat    write data, low byte at addr, high byte at addr+1
//   o_dat    read data, valid only while o_ack=1, zero otherwise
//   i_bs     byte select, 00 = no request
//   i_we     1 = write, 0 = read
//   o_ack    one-cycle completion strobe
//
// Parameters
//   AW       byte address width, memory holds 2^AW bytes
//   WAIT     wait-state cycles inserted before ack (0..15)
//
// FSM states
//   state      | meaning
//   ST_IDLE    | waiting for a request (i_bs != 00)
//   ST_WAITING | request captured, counting down wait states
//   ST_ACK     | o_ack high for one cycle; a write commits on the edge ending it
module prim_mem #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic [1:0]  i_bs,
  input  logic        i_we,
  output logic        o_ack
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAITING = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;

  // The counter is loaded with WAIT-1 so that WAIT cycles are spent in
  // ST_WAITING, terminal count 0 moving to ST_ACK.
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   dat_q, dat_d;
  logic [1:0]    bs_q, bs_d;
  logic          we_q, we_d;

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] a0, a1;
  logic [7:0]    rd_lo, rd_hi;

  // Address bits above AW are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^i_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    bs_d    = bs_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (i_bs != 2'b00) begin
          addr_d  = i_addr[AW-1:0];
          dat_d   = i_dat;
          bs_d    = i_bs;
          we_d    = i_we;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT > 0) ? ST_WAITING : ST_ACK;
        end
      end
      ST_WAITING: begin
        // Withdrawal takes priority over the terminal count.
        if (i_bs == 2'b00) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      dat_q   <= 16'h0000;
      bs_q    <= 2'b00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      bs_q    <= bs_d;
      we_q    <= we_d;
    end
  end

  // Second byte wraps within the array.
  assign a0 = addr_q;
  assign a1 = addr_q + AW'(1);

  // o_ack decodes straight from the reset flop, so reset clears it (and
  // therefore o_dat and any pending write) asynchronously.
  assign o_ack = (state_q == ST_ACK);

  always_comb begin
    rd_lo = bs_q[0] ? mem[a0] : 8'h00;
    rd_hi = bs_q[1] ? mem[a1] : 8'h00;
    o_dat = (o_ack && !we_q) ? {rd_hi, rd_lo} : 16'h0000;
  end

  // Memory contents are neither initialised nor reset.
  always_ff @(posedge i_clk) begin
    if (o_ack && we_q) begin
      if (bs_q[0]) mem[a0] <= dat_q[7:0];
      if (bs_q[1]) mem[a1] <= dat_q[15:8];
    end
  end

endmodule

// File: tb/tb_prim_mem.sv
module tb_prim_mem;

  logic             clk;
  logic [1:0]       rst;
  logic [1:0][15:0] i_addr;
  logic [1:0][15:0] i_dat;
  logic [1:0][15:0] o_dat;
  logic [1:0][1:0]  i_bs;
  logic [1:0]       i_we;
  logic [1:0]       o_ack;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit run_cmp = 0;

  int waits [2] = '{0, 3};
  int ack_cycle [2] = '{-1, -1};
  logic [15:0] exp_dat [2];
  logic [15:0] exp_mask [2];

  // Reference byte arrays; kn marks bytes that have been written.
  logic [7:0] mm [2][1024];
  bit         kn [2][1024];

  prim_mem #(.AW(10), .WAIT(0)) u0 (
    .i_clk(clk), .i_reset(rst[0]), .i_addr(i_addr[0]), .i_dat(i_dat[0]),
    .o_dat(o_dat[0]), .i_bs(i_bs[0]), .i_we(i_we[0]), .o_ack(o_ack[0]));

  prim_mem #(.AW(10), .WAIT(3)) u1 (
    .i_clk(clk), .i_reset(rst[1]), .i_addr(i_addr[1]), .i_dat(i_dat[1]),
    .o_dat(o_dat[1]), .i_bs(i_bs[1]), .i_we(i_we[1]), .o_ack(o_ack[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every cycle: ack exactly on the model's ack cycle, data masked to known bytes.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc == ack_cycle[k]) begin
          chk($sformatf("ack%0d", k), {31'd0, o_ack[k]}, 32'd1);
          chk($sformatf("dat%0d", k), {16'd0, o_dat[k] & exp_mask[k]},
              {16'd0, exp_dat[k] & exp_mask[k]});
        end else begin
          chk($sformatf("noack%0d", k), {31'd0, o_ack[k]}, 32'd0);
          chk($sformatf("dat_idle%0d", k), {16'd0, o_dat[k]}, 32'd0);
        end
      end
    end
  end

  // mode 0: normal; 1: withdraw in wait cycle 2; 2: reset in wait cycle 2;
  // 3: request presented while in reset, held across deassertion.
  task automatic txn(input int k, input logic we, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] bs, input int mode,
                     output logic [15:0] rd, output int lat);
    logic [9:0] a0, a1;
    int acc;
    bit got;
    a0  = a[9:0];
    a1  = a0 + 10'd1;
    rd  = 16'h0000;
    lat = -1;
    @(posedge clk); #1;
    if (mode == 3) rst[k] = 1'b1;
    i_addr[k] = a;
    i_dat[k]  = d;
    i_bs[k]   = bs;
    i_we[k]   = we;
    if (mode == 3) begin #2; rst[k] = 1'b0; end
    exp_dat[k]  = 16'h0000;
    exp_mask[k] = 16'hFFFF;
    if (!we) begin
      if (bs[0]) begin
        exp_dat[k][7:0]  = mm[k][a0];
        exp_mask[k][7:0] = kn[k][a0] ? 8'hFF : 8'h00;
      end
      if (bs[1]) begin
        exp_dat[k][15:8]  = mm[k][a1];
        exp_mask[k][15:8] = kn[k][a1] ? 8'hFF : 8'h00;
      end
    end
    acc = cyc + 1;
    ack_cycle[k] = acc + waits[k];
    @(posedge clk); #1;
    // Captured request must ignore these changes.
    i_addr[k] = 16'($urandom);
    i_dat[k]  = 16'($urandom);
    i_we[k]   = 1'($urandom);
    i_bs[k]   = 2'($urandom_range(1, 3));
    if (mode == 1 || mode == 2) begin
      @(posedge clk); #1;
      ack_cycle[k] = -1;
      i_bs[k] = 2'b00;
      if (mode == 2) begin rst[k] = 1'b1; #2; rst[k] = 1'b0; end
      repeat (waits[k] + 3) @(posedge clk);
      return;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_ack[k]) begin
        got = 1;
        lat = cyc - acc + 1;
        rd  = o_dat[k];
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (we) begin
      if (bs[0]) begin mm[k][a0] = d[7:0];  kn[k][a0] = 1; end
      if (bs[1]) begin mm[k][a1] = d[15:8]; kn[k][a1] = 1; end
    end
    i_bs[k] = 2'b00;
  endtask

  logic [15:0] rd;
  int lat;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 1024; j++) begin
        mm[k][j] = 8'h00;
        kn[k][j] = 0;
      end
    rst = 2'b11;
    i_addr = '0; i_dat = '0; i_bs = '0; i_we = '0;
    exp_dat = '{16'h0, 16'h0};
    exp_mask = '{16'hFFFF, 16'hFFFF};
    run_cmp = 1;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;

    // WAIT=0 instance
    txn(0, 1, 16'h0010, 16'hBEEF, 2'b11, 0, rd, lat);
    chk("w_lat0", lat, 1);
    txn(0, 0, 16'h0010, 16'h0000, 2'b11, 0, rd, lat);
    chk("rd_beef", {16'd0, rd}, 32'h0000BEEF);
    chk("r_lat0", lat, 1);
    txn(0, 0, 16'h0011, 16'h0000, 2'b11, 0, rd, lat);
    chk("rd_unal_lo", {24'd0, rd[7:0]}, 32'h000000BE);
    txn(0, 0, 16'h0011, 16'h0000, 2'b01, 0, rd, lat);
    chk("rd_bs01", {16'd0, rd}, 32'h000000BE);
    txn(0, 1, 16'h03FF, 16'h1234, 2'b11, 0, rd, lat);
    txn(0, 0, 16'h0400, 16'h0000, 2'b01, 0, rd, lat);
    chk("rd_wrap", {16'd0, rd}, 32'h00000012);
    txn(0, 0, 16'h03FF, 16'h0000, 2'b11, 0, rd, lat);
    chk("rd_wrap16", {16'd0, rd}, 32'h00001234);
    txn(0, 1, 16'h0030, 16'h1122, 2'b11, 0, rd, lat);
    txn(0, 1, 16'h0030, 16'h5500, 2'b10, 0, rd, lat);
    txn(0, 0, 16'h0030, 16'h0000, 2'b11, 0, rd, lat);
    chk("rd_bs10_merge", {16'd0, rd}, 32'h00005522);
    txn(0, 0, 16'hFC30, 16'h0000, 2'b11, 3, rd, lat);
    chk("rd_alias_rst", {16'd0, rd}, 32'h00005522);
    chk("lat_after_rst", lat, 1);

    // WAIT=3 instance
    txn(1, 1, 16'h0020, 16'h5A5A, 2'b11, 0, rd, lat);
    chk("w_lat3", lat, 4);
    txn(1, 0, 16'h0020, 16'h0000, 2'b11, 0, rd, lat);
    chk("r_lat3", lat, 4);
    chk("rd_5a5a", {16'd0, rd}, 32'h00005A5A);
    txn(1, 1, 16'h0020, 16'hAAAA, 2'b11, 1, rd, lat);
    txn(1, 0, 16'h0020, 16'h0000, 2'b11, 0, rd, lat);
    chk("rd_after_withdraw", {16'd0, rd}, 32'h00005A5A);
    txn(1, 1, 16'h0020, 16'hAAAA, 2'b11, 2, rd, lat);
    txn(1, 0, 16'h0020, 16'h0000, 2'b10, 0, rd, lat);
    chk("rd_after_reset", {16'd0, rd}, 32'h00005A00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int k, mode;
      logic [9:0] lo;
      logic [15:0] a;
      k = $urandom_range(0, 1);
      mode = 0;
      if (k == 1 && $urandom_range(0, 7) == 0) mode = $urandom_range(1, 2);
      else if ($urandom_range(0, 15) == 0) mode = 3;
      lo = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15))
                                       : 10'(1008 + $urandom_range(0, 15));
      a = {6'($urandom), lo};
      txn(k, 1'($urandom), a, 16'($urandom), 2'($urandom_range(1, 3)), mode, rd, lat);
    end

    repeat (4) @(posedge clk);
    run_cmp = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prim_mem.md
PRIM_MEM -- requirements
Module: prim_mem

Interface
REQ-001 SHALL have parameter AW, default 10, meaning byte-array address width (memory size 2^AW bytes).
REQ-002 SHALL have parameter WAIT, default 0, meaning wait-state cycles inserted before ack (legal 0..15).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_addr  input  16  byte address from bus initiator.
REQ-006 SHALL have port i_dat  input  16  write data, low byte at i_addr, high byte at i_addr+1.
REQ-007 SHALL have port o_dat  output  16  read data, valid only while o_ack=1.
REQ-008 SHALL have port i_bs  input  2  byte select; 00 = no request, nonzero = request active.
REQ-009 SHALL have port i_we  input  1  1 = write, 0 = read; qualified by i_bs≠00.
REQ-010 SHALL have port o_ack  output  1  one-cycle completion strobe.

Function
REQ-011 SHALL implement states IDLE, WAITING, ACK.
REQ-012 SHALL, in IDLE with i_bs≠00, capture i_addr, i_dat, i_bs and i_we, and go to WAITING if WAIT>0, else to ACK.
REQ-013 SHALL, in WAITING, count down WAIT cycles, then go to ACK; latency from request accept to o_ack high = WAIT+1 cycles.
REQ-014 SHALL, in WAITING, return to IDLE with no ack and no write if i_bs goes to 00 (request withdrawn).
REQ-015 SHALL assert o_ack for exactly one cycle in ACK, then return to IDLE unconditionally; the next request is sampled in the following cycle (the initiator changes its request on the ack edge).
REQ-016 SHALL ignore changes to i_addr, i_dat, i_bs and i_we after capture until the transaction ends.
REQ-017 SHALL form effective byte addresses A0 = captured addr[AW-1:0] and A1 = (addr+1)[AW-1:0], wrapping modulo 2^AW (e.g. AW=10: 0x3FF+1 -> 0x000); address bits above AW are ignored (aliasing).
REQ-018 SHALL support unaligned 16-bit access at any byte address.
REQ-019 SHALL, on a read, drive o_dat during ACK as follows: bs=11 -> {mem[A1], mem[A0]}; bs=01 -> {8'h00, mem[A0]}; bs=10 -> {mem[A1], 8'h00}.
REQ-020 SHALL drive o_dat = 16'h0000 whenever o_ack=0.
REQ-021 SHALL, on a write, commit at the clock edge ending the ACK cycle: bs=01 -> mem[A0]=dat[7:0]; bs=10 -> mem[A1]=dat[15:8]; bs=11 -> both; unselected bytes SHALL be unchanged.
REQ-022 SHALL drive o_dat = 16'h0000 during a write ack.
REQ-023 SHALL return, for a read issued immediately after a write to the same bytes, the newly written data.
REQ-024 SHALL NOT initialise memory contents; reads of never-written bytes are don't-care.

Reset
REQ-025 SHALL, while i_reset=1 (asynchronously), force state IDLE, wait counter 0, o_ack=0 and o_dat=0.
REQ-026 SHALL, when reset occurs mid-transaction, suppress any pending write and produce no ack.
REQ-027 SHALL NOT clear memory contents on reset.
REQ-028 SHALL accept a request held across reset deassertion as a new request on the first edge after deassertion.

Verification
REQ-029 SHALL be verified by this scenario: WAIT=0, write bs=11 addr=0x0010 dat=0xBEEF, then read bs=11 addr=0x0010 -> o_ack 1 cycle after each accept, read o_dat=0xBEEF.
REQ-030 SHALL be verified by this scenario: after REQ-029, read bs=11 addr=0x0011 -> o_dat={mem[0x12],0xBE}; read bs=01 addr=0x0011 -> o_dat=0x00BE.
REQ-031 SHALL be verified by this scenario: AW=10, write bs=11 addr=0x03FF dat=0x1234 -> mem[0x3FF]=0x34, mem[0x000]=0x12; read bs=01 addr=0x0400 -> 0x0012.
REQ-032 SHALL be verified by this scenario: WAIT=3, read request -> o_ack high exactly 4 cycles after accept, low otherwise, o_dat=0 when not acked.
REQ-033 SHALL be verified by this scenario: WAIT=3, write 0xAAAA to 0x0020 with i_bs dropped to 00 in cycle 2 -> no ack, mem[0x20..0x21] unchanged; same with i_reset pulsed in cycle 2 -> same result, o_ack=0.
REQ-034 SHALL be verified by this scenario: write bs=10 addr=0x0030 dat=0x5500 over prior 0x1122 at 0x30 -> mem[0x30]=0x22, mem[0x31]=0x55.
